// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parallel-load register with multi-step lane shift/rotate commands.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted when both high at a rising edge)
//   cmd_mode              000 nop, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 11x nop
//   cmd_count             step count for shift/rotate
//   parallel_in           load data
//   serial_in_l/_r        lane inserted at LSB end (left shift) / MSB end (right shift)
//   parallel_out          register contents
//   serial_out_l/_r       top / bottom lane of the register
//   busy, done            multi-step in progress, one-cycle completion pulse
// Define UNI_SHIFT_ROTATE_EN to build the rotate modes; otherwise 100/101 act as nop.
module universal_shift_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 1,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_mode,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  input  logic [LANE_WIDTH-1:0] serial_in_l,
  input  logic [LANE_WIDTH-1:0] serial_in_r,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic [LANE_WIDTH-1:0] serial_out_l,
  output logic [LANE_WIDTH-1:0] serial_out_r,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic {IDLE, SHIFTING} state_t;
  state_t                  state, nxt_state;
  logic [DATA_WIDTH-1:0]   data, nxt_data, step_data;
  logic [LANE_WIDTH-1:0]   ins_l, ins_r;
  logic [CNT_WIDTH-1:0]    rem, nxt_rem;
  logic                    right_q, cur_right, armed, nxt_done, is_move;
`ifdef UNI_SHIFT_ROTATE_EN
  logic                    rot_q, cur_rot;
`endif
  assign cmd_ready    = (state == IDLE) && armed;
  assign busy         = (state == SHIFTING);
  assign parallel_out = data;
  assign serial_out_l = data[DATA_WIDTH-1 -: LANE_WIDTH];
  assign serial_out_r = data[LANE_WIDTH-1:0];
  // Direction comes from the live command on the acceptance edge, from the latched copy afterwards.
  always_comb begin
    cur_right = busy ? right_q : cmd_mode[0];
`ifdef UNI_SHIFT_ROTATE_EN
    cur_rot   = busy ? rot_q : cmd_mode[2];
    ins_l     = cur_rot ? data[DATA_WIDTH-1 -: LANE_WIDTH] : serial_in_l;
    ins_r     = cur_rot ? data[LANE_WIDTH-1:0] : serial_in_r;
    is_move   = cmd_mode inside {3'b010, 3'b011, 3'b100, 3'b101};
`else
    ins_l     = serial_in_l;
    ins_r     = serial_in_r;
    is_move   = cmd_mode inside {3'b010, 3'b011};
`endif
    // Concatenate-and-truncate also covers LANE_WIDTH == DATA_WIDTH.
    step_data = cur_right ? DATA_WIDTH'({ins_r, data} >> LANE_WIDTH) : DATA_WIDTH'({data, ins_l});
  end
  always_comb begin
    nxt_state = state;
    nxt_data  = data;
    nxt_rem   = rem;
    nxt_done  = 1'b0;
    if (busy) begin
      nxt_data = step_data;
      nxt_rem  = rem - CNT_WIDTH'(1);
      nxt_state = (rem == CNT_WIDTH'(1)) ? IDLE : SHIFTING;
      nxt_done  = (rem == CNT_WIDTH'(1));
    end else if (cmd_valid && cmd_ready) begin
      nxt_done = 1'b1;
      if (cmd_mode == 3'b001) nxt_data = parallel_in;
      else if (is_move && cmd_count != '0) begin
        nxt_data  = step_data;
        nxt_rem   = cmd_count - CNT_WIDTH'(1);
        nxt_state = (cmd_count == CNT_WIDTH'(1)) ? IDLE : SHIFTING;
        nxt_done  = (cmd_count == CNT_WIDTH'(1));
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      data    <= '0;
      rem     <= '0;
      right_q <= 1'b0;
      done    <= 1'b0;
      armed   <= 1'b0;
`ifdef UNI_SHIFT_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state   <= nxt_state;
      data    <= nxt_data;
      rem     <= nxt_rem;
      done    <= nxt_done;
      armed   <= 1'b1;
      right_q <= busy ? right_q : cmd_mode[0];
`ifdef UNI_SHIFT_ROTATE_EN
      rot_q   <= busy ? rot_q : cmd_mode[2];
`endif
    end
  end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed stimulus, behavioural model compare plus hand-computed pins.
module tb_universal_shift_reg;
`ifdef UNI_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd_mode = '0;
  logic [3:0] cmd_count = '0;
  logic [7:0] parallel_in = '0, parallel_out;
  logic       serial_in_l = 1'b0, serial_in_r = 1'b0;
  logic       serial_out_l, serial_out_r, cmd_ready, busy, done;
  universal_shift_reg dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .parallel_in(parallel_in),
    .serial_in_l(serial_in_l), .serial_in_r(serial_in_r), .parallel_out(parallel_out),
    .serial_out_l(serial_out_l), .serial_out_r(serial_out_r), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  // Model: register value as an integer, steps still owed, and the latched mode.
  int m_data = 0, m_left = 0, m_mode = 0;
  bit m_done = 0, m_armed = 0;
  function automatic int mv(input int md, input int d, input int sl, input int sr);
    case (md)
      2: return (d * 2 + sl) % 256;
      3: return d / 2 + sr * 128;
      4: return (d * 2 + d / 128) % 256;
      5: return d / 2 + (d % 2) * 128;
      default: return d;
    endcase
  endfunction
  function automatic bit moves(input int md);
    return md == 2 || md == 3 || (ROT && (md == 4 || md == 5));
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data <= 0; m_left <= 0; m_mode <= 0; m_done <= 0; m_armed <= 0;
    end else begin
      m_armed <= 1;
      m_done  <= 0;
      if (m_left > 0) begin
        m_data <= mv(m_mode, m_data, int'(serial_in_l), int'(serial_in_r));
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end else if (cmd_valid && m_armed) begin
        if (cmd_mode == 1) begin
          m_data <= int'(parallel_in);
          m_done <= 1;
        end else if (moves(int'(cmd_mode)) && cmd_count > 0) begin
          m_data <= mv(int'(cmd_mode), m_data, int'(serial_in_l), int'(serial_in_r));
          m_left <= int'(cmd_count) - 1;
          m_mode <= int'(cmd_mode);
          m_done <= (cmd_count == 1);
        end else m_done <= 1;
      end
    end
  end
  // Hand-computed pins: -1 means don't care; pin_seq changes whenever a new set is posted.
  int    pin_po, pin_busy, pin_done, pin_rdy, pin_seq = 0, seen = 0;
  string pin_tag;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model.po", int'(parallel_out), m_data);
    chk("model.sol", int'(serial_out_l), m_data / 128);
    chk("model.sor", int'(serial_out_r), m_data % 2);
    chk("model.busy", int'(busy), int'(m_left > 0));
    chk("model.done", int'(done), int'(m_done));
    chk("model.ready", int'(cmd_ready), int'(m_armed && m_left == 0));
    if (pin_seq != seen) begin
      seen = pin_seq;
      if (pin_po >= 0) chk({pin_tag, ".po"}, int'(parallel_out), pin_po);
      if (pin_busy >= 0) chk({pin_tag, ".busy"}, int'(busy), pin_busy);
      if (pin_done >= 0) chk({pin_tag, ".done"}, int'(done), pin_done);
      if (pin_rdy >= 0) chk({pin_tag, ".ready"}, int'(cmd_ready), pin_rdy);
    end
  end
  task automatic tick(input string tag, input int po, input int b, input int d, input int r);
    @(posedge clk);
    #1;
    pin_tag = tag; pin_po = po; pin_busy = b; pin_done = d; pin_rdy = r;
    pin_seq++;
  endtask
  task automatic issue(input int md, input int cnt, input int pin, input bit sl, input bit sr);
    cmd_valid = 1'b1; cmd_mode = 3'(md); cmd_count = 4'(cnt); parallel_in = 8'(pin);
    serial_in_l = sl; serial_in_r = sr;
  endtask
  initial begin
    tick("rst", 0, 0, 0, 0);
    reset = 1'b0;
    tick("rdy", 0, 0, 0, 1);
    issue(1, 0, 8'hA5, 0, 0);
    tick("ldA5", 8'hA5, 0, 1, 1);
    cmd_valid = 1'b0;
    tick("ldA5b", 8'hA5, 0, 0, 1);
    issue(1, 0, 8'h81, 0, 0);
    tick("ld81", 8'h81, 0, 1, 1);
    issue(2, 3, 0, 1, 0);
    tick("shl1", 8'h03, 1, 0, 0);
    cmd_valid = 1'b0;
    tick("shl2", 8'h07, 1, 0, 0);
    tick("shl3", 8'h0F, 0, 1, 1);
    tick("shl4", 8'h0F, 0, 0, 1);
    issue(1, 0, 8'h01, 0, 0);
    tick("ld01", 8'h01, 0, 1, 1);
    issue(5, 1, 0, 0, 0);
    tick("ror1", ROT ? 8'h80 : 8'h01, 0, 1, 1);
    issue(1, 0, 8'hFF, 0, 0);
    tick("ldFF", 8'hFF, 0, 1, 1);
    issue(3, 8, 0, 0, 0);
    tick("shr1", 8'h7F, 1, 0, 0);
    issue(1, 0, 8'h55, 0, 0);
    for (int k = 2; k <= 8; k++) tick("shr", 8'hFF >> k, int'(k < 8), int'(k == 8), int'(k == 8));
    tick("ld55", 8'h55, 0, 1, 1);
    issue(2, 10, 0, 1, 0);
    tick("abt1", 8'hAB, 1, 0, 0);
    cmd_valid = 1'b0;
    tick("abt2", 8'h57, 1, 0, 0);
    tick("abt3", 8'hAF, 1, 0, 0);
    tick("abt4", 0, 0, 0, 0);
    reset = 1'b1;
    tick("abt5", 0, 0, 0, 0);
    reset = 1'b0;
    tick("abt6", 0, 0, 0, -1);
    tick("abt7", 0, 0, 0, 1);
    issue(1, 0, 8'h3C, 0, 0);
    tick("ld3C", 8'h3C, 0, 1, 1);
    issue(3, 0, 0, 1, 1);
    tick("n0", 8'h3C, 0, 1, 1);
    cmd_valid = 1'b0;
    tick("n0b", 8'h3C, 0, 0, 1);
    issue(6, 5, 0, 1, 1);
    tick("nop6", 8'h3C, 0, 1, 1);
    issue(4, 9, 0, 0, 0);
    tick("rol9", -1, int'(ROT), int'(!ROT), int'(!ROT));
    cmd_valid = 1'b0;
    repeat (8) tick("rolw", -1, -1, -1, -1);
    tick("rol9z", ROT ? 8'h78 : 8'h3C, 0, 0, 1);
    issue(3, 10, 0, 0, 1);
    tick("shr10a", -1, 1, 0, 0);
    cmd_valid = 1'b0;
    repeat (9) tick("shr10w", -1, -1, -1, -1);
    tick("shr10z", 8'hFF, 0, 0, 1);
    tick("end", -1, -1, -1, -1);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
